// File: rtl/design2_stim_chk.sv
// design2_stim_chk: vector generator and cycle-exact golden checker for design2.
// Ports: clk, reset (async low); start/num_vec/seed control a run;
//   a_o/b_o drive design2, s1_i/s2_i come back from it;
//   busy/done/pass/err_cnt report status.
// Optional first-mismatch capture ports when CHK_CAPTURE_EN is defined:
//   cap_valid, cap_idx, cap_exp_s1, cap_got_s1, cap_exp_s2, cap_got_s2.
module design2_stim_chk #(
    parameter int NV_W      = 16,
    parameter int ERR_W     = 16,
    parameter int FLUSH_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NV_W-1:0]   num_vec,
    input  logic [15:0]       seed,
    output logic [7:0]        a_o,
    output logic [7:0]        b_o,
    input  logic [7:0]        s1_i,
    input  logic [15:0]       s2_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt
`ifdef CHK_CAPTURE_EN
    ,
    output logic              cap_valid,
    output logic [NV_W+2:0]   cap_idx,
    output logic [7:0]        cap_exp_s1,
    output logic [7:0]        cap_got_s1,
    output logic [15:0]       cap_exp_s2,
    output logic [15:0]       cap_got_s2
`endif
);

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [15:0] LFSR_DFLT = 16'hACE1;
    localparam int          FW        = $clog2(FLUSH_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NV_W-1:0]  vc_q, vc_d;
    logic [FW-1:0]    fc_q, fc_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [ERR_W-1:0] err_q, err_d;

    // Golden mirror of the design2 pipeline.
    logic [5:0]  mc_q;
    logic [7:0]  m1_q, m2_q, m3_q, m4_q, m5_q;
    logic [15:0] m6_q;

    logic active;
    logic mis;

    assign active  = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign mis     = (s1_i != m5_q) || (s2_i != m6_q);

    assign a_o     = (state_q == S_RUN) ? lfsr_q[7:0]  : 8'h00;
    assign b_o     = (state_q == S_RUN) ? lfsr_q[15:8] : 8'h00;
    assign busy    = active;
    assign done    = (state_q == S_DONE);
    assign pass    = (state_q == S_DONE) && (err_q == '0);
    assign err_cnt = err_q;

    always_comb begin
        state_d = state_q;
        vc_d    = vc_q;
        fc_d    = fc_q;
        lfsr_d  = lfsr_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vc_d    = num_vec;
                    fc_d    = '0;
                    err_d   = '0;
                    lfsr_d  = (seed == 16'h0) ? LFSR_DFLT : seed;
                    state_d = (num_vec == '0) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                lfsr_d = {1'b0, lfsr_q[15:1]}
                       ^ (lfsr_q[0] ? LFSR_MASK : 16'h0);
                if (vc_q == NV_W'(1)) begin
                    state_d = S_FLUSH;
                end else begin
                    vc_d = vc_q - NV_W'(1);
                end
            end
            S_FLUSH: begin
                if (fc_q == FW'(FLUSH_CYC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    fc_d = fc_q + FW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // One count per bad cycle, pinned at all-ones.
        if (active && mis && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            vc_q    <= '0;
            fc_q    <= '0;
            lfsr_q  <= LFSR_DFLT;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            vc_q    <= vc_d;
            fc_q    <= fc_d;
            lfsr_q  <= lfsr_d;
            err_q   <= err_d;
        end
    end

    // The mirror free-runs in every state so it stays aligned with design2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mc_q <= '0;
            m1_q <= '0;
            m2_q <= '0;
            m3_q <= '0;
            m4_q <= '0;
            m5_q <= '0;
            m6_q <= '0;
        end else begin
            mc_q <= mc_q - 6'd1;
            m1_q <= a_o;
            m2_q <= b_o;
            m3_q <= m1_q + {2'b00, mc_q};
            m4_q <= m1_q + {2'b00, mc_q} + m5_q;
            m5_q <= m4_q;
            m6_q <= 16'(m2_q) * 16'(m3_q);
        end
    end

`ifdef CHK_CAPTURE_EN
    logic            accept;
    logic [NV_W+2:0] cyc_q;

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Keep only the first mismatch of a run; idx 0 is the first busy cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q      <= '0;
            cap_valid  <= 1'b0;
            cap_idx    <= '0;
            cap_exp_s1 <= '0;
            cap_got_s1 <= '0;
            cap_exp_s2 <= '0;
            cap_got_s2 <= '0;
        end else if (accept) begin
            cyc_q      <= '0;
            cap_valid  <= 1'b0;
            cap_idx    <= '0;
            cap_exp_s1 <= '0;
            cap_got_s1 <= '0;
            cap_exp_s2 <= '0;
            cap_got_s2 <= '0;
        end else if (active) begin
            cyc_q <= cyc_q + (NV_W+3)'(1);
            if (mis && !cap_valid) begin
                cap_valid  <= 1'b1;
                cap_idx    <= cyc_q;
                cap_exp_s1 <= m5_q;
                cap_got_s1 <= s1_i;
                cap_exp_s2 <= m6_q;
                cap_got_s2 <= s2_i;
            end
        end
    end
`endif

endmodule

// File: tb/tb_design2_stim_chk.sv
// tb_design2_stim_chk: scoreboard bench for design2_stim_chk.
// Two checkers (ERR_W=16 and ERR_W=4), each with a behavioural design2 stand-in.
module tb_design2_stim_chk;

    typedef struct packed {
        logic [5:0]  mc;
        logic [7:0]  m1;
        logic [7:0]  m2;
        logic [7:0]  m3;
        logic [7:0]  m4;
        logic [7:0]  m5;
        logic [15:0] m6;
    } d2_t;

    typedef struct packed {
        logic [15:0] err;
        logic        pass;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        st16 = 1'b0, st4 = 1'b0;
    logic [15:0] nv16 = '0, nv4 = '0, sd16 = '0, sd4 = '0;
    logic [7:0]  a16, b16, a4, b4, s1_16, s1_4;
    logic [15:0] s2_16, s2_4;
    logic        busy16, done16, pass16, busy4, done4, pass4;
    logic [15:0] err16;
    logic [3:0]  err4;
    logic        f16 = 1'b0, inv4 = 1'b0;

`ifdef CHK_CAPTURE_EN
    logic        cv16, cv4;
    logic [18:0] ci16, ci4;
    logic [7:0]  ce1_16, cg1_16, ce1_4, cg1_4;
    logic [15:0] ce2_16, cg2_16, ce2_4, cg2_4;
`endif

    d2_t e16, e4;

    int total = 0;
    int bad = 0;

    logic [15:0] qab16[$], qab4[$];
    res_t        qr16[$], qr4[$];

    design2_stim_chk #(.NV_W(16), .ERR_W(16), .FLUSH_CYC(4)) u16 (
        .clk(clk), .reset(reset), .start(st16), .num_vec(nv16), .seed(sd16),
        .a_o(a16), .b_o(b16), .s1_i(s1_16), .s2_i(s2_16),
        .busy(busy16), .done(done16), .pass(pass16), .err_cnt(err16)
`ifdef CHK_CAPTURE_EN
        , .cap_valid(cv16), .cap_idx(ci16), .cap_exp_s1(ce1_16),
        .cap_got_s1(cg1_16), .cap_exp_s2(ce2_16), .cap_got_s2(cg2_16)
`endif
    );

    design2_stim_chk #(.NV_W(16), .ERR_W(4), .FLUSH_CYC(4)) u4 (
        .clk(clk), .reset(reset), .start(st4), .num_vec(nv4), .seed(sd4),
        .a_o(a4), .b_o(b4), .s1_i(s1_4), .s2_i(s2_4),
        .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4)
`ifdef CHK_CAPTURE_EN
        , .cap_valid(cv4), .cap_idx(ci4), .cap_exp_s1(ce1_4),
        .cap_got_s1(cg1_4), .cap_exp_s2(ce2_4), .cap_got_s2(cg2_4)
`endif
    );

    // design2 behaviour: one clock step of its registers.
    function automatic d2_t d2_step(d2_t s, logic [7:0] a, logic [7:0] b);
        d2_t n;
        n.mc = s.mc - 6'd1;
        n.m1 = a;
        n.m2 = b;
        n.m3 = s.m1 + 8'(s.mc);
        n.m4 = s.m1 + 8'(s.mc) + s.m5;
        n.m5 = s.m4;
        n.m6 = 16'(s.m2) * 16'(s.m3);
        return n;
    endfunction

    function automatic logic [15:0] lfsr_nx(logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e16 <= '0;
            e4  <= '0;
        end else begin
            e16 <= d2_step(e16, a16, b16);
            e4  <= d2_step(e4, a4, b4);
        end
    end

    assign s1_16 = e16.m5;
    assign s2_16 = f16 ? {e16.m6[15:1], 1'b0} : e16.m6;
    assign s1_4  = inv4 ? ~e4.m5 : e4.m5;
    assign s2_4  = e4.m6;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endfunction

    // mode 0: clean, 1: s2 bit0 forced low, 2: s1 inverted (u4 only)
    task automatic issue(input bit on4, input int n, input logic [15:0] sd,
                         input int mode);
        logic [15:0] x;
        logic [15:0] vq[$];
        d2_t s;
        int err;
        res_t r;
        x = (sd == 16'h0) ? 16'hACE1 : sd;
        for (int i = 0; i < n; i++) begin
            vq.push_back(x);
            x = lfsr_nx(x);
        end
        for (int i = 0; i < 4; i++) vq.push_back(16'h0);
        err = 0;
        if (mode == 1) begin
            // design2 sees a=b=0 on the accepting edge, then the vector list.
            s = d2_step(e16, 8'h00, 8'h00);
            foreach (vq[k]) begin
                if (s.m6[0]) err++;
                s = d2_step(s, vq[k][7:0], vq[k][15:8]);
            end
        end else if (mode == 2) begin
            err = n + 4;
        end
        if (on4 && err > 15) err = 15;
        r.err = 16'(err);
        r.pass = (err == 0);
        if (on4) begin
            foreach (vq[k]) qab4.push_back(vq[k]);
            qr4.push_back(r);
            inv4 = (mode == 2);
            nv4 = 16'(n);
            sd4 = sd;
            st4 = 1'b1;
        end else begin
            foreach (vq[k]) qab16.push_back(vq[k]);
            qr16.push_back(r);
            f16 = (mode == 1);
            nv16 = 16'(n);
            sd16 = sd;
            st16 = 1'b1;
        end
        @(negedge clk);
        st16 = 1'b0;
        st4 = 1'b0;
    endtask

    task automatic wait_done(input bit on4, input int lim);
        int c;
        c = 0;
        while (!(on4 ? done4 : done16) && c < lim) begin
            @(negedge clk);
            c++;
        end
        if (!(on4 ? done4 : done16)) begin
            total++;
            bad++;
            $display("FAIL timeout%s done=0 required=1", on4 ? "4" : "16");
        end
        @(negedge clk);
    endtask

    // Monitor: pops expected a/b while busy, expected result on done rise.
    initial begin
        logic pd16, pd4;
        logic [15:0] x;
        res_t r;
        pd16 = 1'b0;
        pd4 = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pd16 = 1'b0;
                pd4 = 1'b0;
            end else begin
                if (busy16) begin
                    if (qab16.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL busy16 got busy=1 required idle");
                    end else begin
                        x = qab16.pop_front();
                        chk("ab16", {b16, a16}, x);
                    end
                end
                if (busy4) begin
                    if (qab4.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL busy4 got busy=1 required idle");
                    end else begin
                        x = qab4.pop_front();
                        chk("ab4", {b4, a4}, x);
                    end
                end
                if (done16 && !pd16) begin
                    chk("len16", qab16.size(), 0);
                    if (qr16.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL done16 got done=1 required none");
                    end else begin
                        r = qr16.pop_front();
                        chk("err16", err16, r.err);
                        chk("pass16", pass16, r.pass);
                    end
                end
                if (done4 && !pd4) begin
                    chk("len4", qab4.size(), 0);
                    if (qr4.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL done4 got done=1 required none");
                    end else begin
                        r = qr4.pop_front();
                        chk("err4", err4, r.err);
                        chk("pass4", pass4, r.pass);
                    end
                end
                pd16 = done16;
                pd4 = done4;
            end
        end
    end

    initial begin
        logic [15:0] rs;
        int rn;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ab16", {b16, a16}, 0);
        chk("rst_st16", {busy16, done16, pass16}, 0);
        chk("rst_err16", err16, 0);
        chk("rst_st4", {busy4, done4, pass4, err4}, 0);
`ifdef CHK_CAPTURE_EN
        chk("rst_cap", {cv16, ci16, ce1_16, cg1_16}, 0);
        chk("rst_cap2", {ce2_16, cg2_16}, 0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Clean run, default seed.
        issue(1'b0, 100, 16'hACE1, 0);
        wait_done(1'b0, 200);

        // Random clean runs.
        for (int i = 0; i < 3; i++) begin
            rs = 16'($urandom);
            rn = int'($urandom_range(1, 40));
            issue(1'b0, rn, rs, 0);
            wait_done(1'b0, 100);
        end

        // Zero-vector run: four flush cycles of a=b=0.
        issue(1'b0, 0, 16'($urandom), 0);
        wait_done(1'b0, 20);

        // s2 bit0 stuck low.
        issue(1'b0, 50, 16'h1234, 1);
        wait_done(1'b0, 100);
        f16 = 1'b0;
        chk("t2_err_pos", (err16 != 0), 1);
`ifdef CHK_CAPTURE_EN
        chk("t2_cap_v", cv16, 1);
        chk("t2_cap_exp0", ce2_16[0], 1);
        chk("t2_cap_got0", cg2_16[0], 0);
`endif

        // Back-to-back restart from DONE.
        chk("t6_pre_done", done16, 1);
        issue(1'b0, 10, 16'($urandom), 0);
        chk("t6_done_low", done16, 0);
        chk("t6_err_clr", err16, 0);
        wait_done(1'b0, 40);

        // Saturating counter, with an ignored start during RUN.
        issue(1'b1, 40, 16'($urandom), 2);
        repeat (10) @(negedge clk);
        nv4 = 16'd3;
        st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0;
        wait_done(1'b1, 100);
        chk("t5_sat", err4, 15);
        inv4 = 1'b0;

        // Reset mid-run takes effect without a clock edge.
        issue(1'b0, 200, 16'($urandom), 0);
        repeat (36) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t4_ab", {b16, a16}, 0);
        chk("t4_bd", {busy16, done16}, 0);
        chk("t4_err", err16, 0);
        qab16.delete();
        qr16.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(1'b0, 5, 16'h0000, 0);
        chk("t4_seed0_a", a16, 8'hE1);
        chk("t4_seed0_b", b16, 8'hAC);
        wait_done(1'b0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
